// File: rtl/mem_wb_pkg.sv
// Shared types and constants for the MEM/WB stage.
package mem_wb_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ADR_WIDTH  = 4;
  localparam int unsigned REG_WIDTH  = 3;
  localparam int unsigned OPC_W      = 4;

  localparam logic [OPC_W-1:0] OPC_ALU   = 4'b0000;
  localparam logic [OPC_W-1:0] OPC_LOAD  = 4'b1000;
  localparam logic [OPC_W-1:0] OPC_STORE = 4'b1001;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // EX/MEM payload as captured at accept
  typedef struct packed {
    logic [ADR_WIDTH-1:0]  adr;
    logic [DATA_WIDTH-1:0] result;
    logic [OPC_W-1:0]      opcode;
    logic [REG_WIDTH-1:0]  dest_reg;
    logic                  reg_we;
    logic                  mem_we;
  } exmem_bundle_t;

  // A store bit always wins over the opcode
  function automatic logic is_load(input exmem_bundle_t b, input logic [OPC_W-1:0] op_load);
    return !b.mem_we && (b.opcode == op_load);
  endfunction

endpackage

// File: rtl/mem_wb_stage_dmem_array.sv
// Data memory: synchronous write, asynchronous read, whole array cleared by reset.
module dmem_array #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADR_W-1:0]  i_wadr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADR_W-1:0]  i_radr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Word write; reset zeroes every word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_wadr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_radr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: accepts EX/MEM bundles, runs the data-memory access, drives the writeback port.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_WIDTH,
  parameter int unsigned ADR_W   = ADR_WIDTH,
  parameter int unsigned REG_W   = REG_WIDTH,
  parameter int unsigned MEM_LAT = 2,
  parameter logic [3:0]  OP_LOAD = OPC_LOAD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADR_W-1:0]  in_mem_adr,
  input  logic [DATA_W-1:0] in_result,
  input  logic [3:0]        in_opcode,
  input  logic [REG_W-1:0]  in_dest_reg,
  input  logic              in_reg_we,
  input  logic              in_mem_we,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_W-1:0]  wb_adr,
  output logic [DATA_W-1:0] wb_data,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic              pend_valid,
  output logic [REG_W-1:0]  pend_reg
);

  localparam int unsigned CNT_W    = 3;
  localparam int unsigned CNT_INIT = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  exmem_bundle_t     r_op;

  exmem_bundle_t     w_in_op;
  exmem_bundle_t     w_cur;
  logic              w_accept;
  logic              w_in_mem;
  logic              w_done_acc;
  logic              w_done_wait;
  logic              w_done;
  logic              w_cur_store;
  logic              w_cur_load;
  logic [DATA_W-1:0] w_rdata;

  // Pack the incoming bundle
  always_comb begin
    w_in_op          = '0;
    w_in_op.adr      = in_mem_adr;
    w_in_op.result   = in_result;
    w_in_op.opcode   = in_opcode;
    w_in_op.dest_reg = in_dest_reg;
    w_in_op.reg_we   = in_reg_we;
    w_in_op.mem_we   = in_mem_we;
  end

  assign in_ready = (r_state == IDLE);
  assign w_accept = in_valid && in_ready;
  assign w_in_mem = in_mem_we || (in_opcode == OP_LOAD);

  // The op completing this edge is the live input in IDLE, the captured one in WAIT
  assign w_cur       = (r_state == WAIT) ? r_op : w_in_op;
  assign w_cur_store = w_cur.mem_we;
  assign w_cur_load  = is_load(w_cur, OP_LOAD);

  assign w_done_acc  = w_accept && (!w_in_mem || (MEM_LAT == 1));
  assign w_done_wait = (r_state == WAIT) && (r_cnt == '0);
  assign w_done      = w_done_acc || w_done_wait;

  dmem_array #(
    .DATA_W (DATA_W),
    .ADR_W  (ADR_W)
  ) u_dmem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_done && w_cur_store),
    .i_wadr  (w_cur.adr),
    .i_wdata (w_cur.result),
    .i_radr  (w_cur.adr),
    .o_rdata (w_rdata)
  );

  // FSM, latency counter, operand capture and writeback registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_adr   <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op <= w_in_op;
            if (w_in_mem && (MEM_LAT > 1)) begin
              r_state <= WAIT;
              r_cnt   <= CNT_W'(CNT_INIT);
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) r_state <= IDLE;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end
        default: r_state <= IDLE;
      endcase
      if (w_done) begin
        wb_valid <= 1'b1;
        wb_we    <= !w_cur_store && w_cur.reg_we;
        wb_adr   <= w_cur.dest_reg;
        wb_data  <= w_cur_load ? w_rdata : w_cur.result;
      end
    end
  end

  assign fwd_valid  = wb_valid && wb_we;
  assign fwd_reg    = wb_adr;
  assign fwd_data   = wb_data;
  assign pend_valid = (r_state == WAIT) && is_load(r_op, OP_LOAD) && r_op.reg_we;
  assign pend_reg   = r_op.dest_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage (MEM_LAT=2).
module tb_mem_wb_stage;

  localparam logic [3:0] OP_LOAD = 4'b1000;
  localparam logic [3:0] OP_ALU  = 4'b0001;
  localparam logic [3:0] OP_ST   = 4'b1001;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [3:0] in_mem_adr;
  logic [7:0] in_result;
  logic [3:0] in_opcode;
  logic [2:0] in_dest_reg;
  logic       in_reg_we, in_mem_we;
  logic       wb_valid, wb_we;
  logic [2:0] wb_adr;
  logic [7:0] wb_data;
  logic       fwd_valid;
  logic [2:0] fwd_reg;
  logic [7:0] fwd_data;
  logic       pend_valid;
  logic [2:0] pend_reg;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(
    .DATA_W (8), .ADR_W (4), .REG_W (3), .MEM_LAT (2), .OP_LOAD (OP_LOAD)
  ) dut (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_ready (in_ready),
    .in_mem_adr (in_mem_adr), .in_result (in_result), .in_opcode (in_opcode),
    .in_dest_reg (in_dest_reg), .in_reg_we (in_reg_we), .in_mem_we (in_mem_we),
    .wb_valid (wb_valid), .wb_we (wb_we), .wb_adr (wb_adr), .wb_data (wb_data),
    .fwd_valid (fwd_valid), .fwd_reg (fwd_reg), .fwd_data (fwd_data),
    .pend_valid (pend_valid), .pend_reg (pend_reg)
  );

  typedef struct {
    logic       v;
    logic [3:0] adr;
    logic [7:0] res;
    logic [3:0] opc;
    logic [2:0] dst;
    logic       rwe;
    logic       mwe;
    logic       e_valid;
    logic       e_we;
    logic [2:0] e_adr;
    logic [7:0] e_data;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] adr, input logic [7:0] res,
                       input logic [3:0] opc, input logic [2:0] dst, input logic rwe,
                       input logic mwe);
    in_valid    = v;
    in_mem_adr  = adr;
    in_result   = res;
    in_opcode   = opc;
    in_dest_reg = dst;
    in_reg_we   = rwe;
    in_mem_we   = mwe;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One memory op: accept, one WAIT cycle with junk inputs, retire, then an idle cycle
  task automatic mem_op(input string tag, input logic [3:0] adr, input logic [7:0] res,
                        input logic [3:0] opc, input logic [2:0] dst, input logic rwe,
                        input logic mwe, input logic e_we, input logic chk_data,
                        input logic [7:0] e_data, input logic e_pend);
    drive(1'b1, adr, res, opc, dst, rwe, mwe);
    tick();
    chk({tag, " ready low in WAIT"}, 32'(in_ready), 32'd0);
    chk({tag, " no wb in WAIT"}, 32'(wb_valid), 32'd0);
    chk({tag, " pend_valid"}, 32'(pend_valid), 32'(e_pend));
    if (e_pend) chk({tag, " pend_reg"}, 32'(pend_reg), 32'(dst));
    drive(1'b1, ~adr, ~res, OP_ALU, ~dst, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'h0, 8'h00, 4'h0, 3'd0, 1'b0, 1'b0);
    chk({tag, " wb_valid"}, 32'(wb_valid), 32'd1);
    chk({tag, " wb_we"}, 32'(wb_we), 32'(e_we));
    chk({tag, " wb_adr"}, 32'(wb_adr), 32'(dst));
    if (chk_data) chk({tag, " wb_data"}, 32'(wb_data), 32'(e_data));
    chk({tag, " fwd_valid"}, 32'(fwd_valid), 32'(e_we));
    chk({tag, " ready back"}, 32'(in_ready), 32'd1);
    chk({tag, " pend cleared"}, 32'(pend_valid), 32'd0);
    tick();
    chk({tag, " wb pulse single"}, 32'(wb_valid), 32'd0);
    chk({tag, " wb_adr holds"}, 32'(wb_adr), 32'(dst));
  endtask

  initial begin
    // {v, adr, res, opc, dst, rwe, mwe, e_valid, e_we, e_adr, e_data}
    vecs[0] = '{1'b1, 4'h2, 8'h5A, OP_ALU, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 8'h5A};
    vecs[1] = '{1'b0, 4'h0, 8'h00, OP_ALU, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 8'h5A};
    vecs[2] = '{1'b1, 4'h1, 8'h11, OP_ALU, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 8'h11};
    vecs[3] = '{1'b1, 4'hF, 8'hFF, 4'hF,   3'd7, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 8'hFF};
    vecs[4] = '{1'b1, 4'h0, 8'h00, 4'h0,   3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'h00};
    vecs[5] = '{1'b0, 4'h5, 8'hEE, OP_LOAD, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 8'h00};

    rst = 1'b1;
    drive(1'b0, 4'h0, 8'h00, 4'h0, 3'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset wb_valid", 32'(wb_valid), 32'd0);
    chk("reset wb_we", 32'(wb_we), 32'd0);
    chk("reset wb_adr", 32'(wb_adr), 32'd0);
    chk("reset wb_data", 32'(wb_data), 32'd0);
    chk("reset fwd_valid", 32'(fwd_valid), 32'd0);
    chk("reset pend_valid", 32'(pend_valid), 32'd0);
    chk("reset pend_reg", 32'(pend_reg), 32'd0);
    rst = 1'b0;

    // Single-cycle ALU ops and idle cycles
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].v, vecs[i].adr, vecs[i].res, vecs[i].opc, vecs[i].dst,
            vecs[i].rwe, vecs[i].mwe);
      tick();
      chk($sformatf("vec%0d wb_valid", i), 32'(wb_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d wb_we", i), 32'(wb_we), 32'(vecs[i].e_we));
      chk($sformatf("vec%0d wb_adr", i), 32'(wb_adr), 32'(vecs[i].e_adr));
      chk($sformatf("vec%0d wb_data", i), 32'(wb_data), 32'(vecs[i].e_data));
      chk($sformatf("vec%0d fwd_valid", i), 32'(fwd_valid),
          32'(vecs[i].e_valid & vecs[i].e_we));
      chk($sformatf("vec%0d fwd_reg", i), 32'(fwd_reg), 32'(vecs[i].e_adr));
      chk($sformatf("vec%0d fwd_data", i), 32'(fwd_data), 32'(vecs[i].e_data));
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
    end
    drive(1'b0, 4'h0, 8'h00, 4'h0, 3'd0, 1'b0, 1'b0);
    tick();

    // Store then load, address boundaries, load of untouched word
    mem_op("st7",  4'h7, 8'hC3, OP_ST,   3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    mem_op("ld7",  4'h7, 8'h00, OP_LOAD, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b1);
    mem_op("ld7d5",4'h7, 8'h44, OP_LOAD, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b1);
    mem_op("ld3",  4'h3, 8'h00, OP_LOAD, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1);
    mem_op("stL9", 4'h9, 8'h77, OP_LOAD, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    mem_op("ld9",  4'h9, 8'h00, OP_LOAD, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 1'b1);
    mem_op("stF",  4'hF, 8'hA5, OP_ST,   3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    mem_op("st0",  4'h0, 8'h3C, OP_ST,   3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    mem_op("ldF",  4'hF, 8'h00, OP_LOAD, 3'd7, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1);
    mem_op("ld0",  4'h0, 8'h00, OP_LOAD, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1);
    mem_op("ldnwe",4'hF, 8'h00, OP_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);

    // Back-to-back: load accepted on the first cycle after the store retires
    drive(1'b1, 4'hB, 8'h42, OP_ST, 3'd1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 4'h0, 8'h00, 4'h0, 3'd0, 1'b0, 1'b0);
    tick();
    chk("b2b store retire", 32'(wb_valid), 32'd1);
    drive(1'b1, 4'hB, 8'h00, OP_LOAD, 3'd1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'h0, 8'h00, 4'h0, 3'd0, 1'b0, 1'b0);
    chk("b2b load accepted", 32'(in_ready), 32'd0);
    tick();
    chk("b2b load wb_valid", 32'(wb_valid), 32'd1);
    chk("b2b load wb_data", 32'(wb_data), 32'h42);

    // Reset during store WAIT aborts the store and clears memory
    tick();
    drive(1'b1, 4'h4, 8'h99, OP_ST, 3'd2, 1'b0, 1'b1);
    tick();
    drive(1'b0, 4'h0, 8'h00, 4'h0, 3'd0, 1'b0, 1'b0);
    chk("rst-wait in WAIT", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst-wait ready", 32'(in_ready), 32'd1);
    chk("rst-wait wb_valid", 32'(wb_valid), 32'd0);
    chk("rst-wait pend", 32'(pend_valid), 32'd0);
    tick();
    chk("rst-wait no pulse", 32'(wb_valid), 32'd0);
    rst = 1'b0;
    tick();
    chk("post-rst no pulse", 32'(wb_valid), 32'd0);
    mem_op("ld4rst", 4'h4, 8'h00, OP_LOAD, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1);
    mem_op("ld7rst", 4'h7, 8'h00, OP_LOAD, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
